// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative 32-bit multiply/divide unit for the MIPS datapath.
// Executes MULT, MULTU, DIV and DIVU over a fixed 34 cycles from the start edge.
// Results go to the HI/LO special registers through one-cycle write strobes.
//
// Ports:
//   clk            system clock, rising edge
//   rst            asynchronous active-high reset
//   start          request a new operation (ignored while busy)
//   op[1:0]        00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   a, b           rs / rt operand values
//   busy           operation in progress (CALC and FIX)
//   done           one-cycle result-valid pulse
//   hi_out         product[63:32] or remainder
//   lo_out         product[31:0] or quotient
//   hi_we, lo_we   HI/LO write strobes, identical to done
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out,
  output logic             hi_we,
  output logic             lo_we
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t           state, state_nx;
  logic [CW-1:0]    cnt;
  logic             accept;

  logic             is_div;
  logic             neg_q;     // quotient / product sign
  logic             neg_r;     // remainder sign (dividend sign)
  logic             b_zero;
  logic [WIDTH-1:0] a_raw;
  logic [WIDTH-1:0] addend;    // multiplicand for MUL, divisor for DIV
  logic [WIDTH-1:0] opr;       // multiplier (shifts right) or dividend (shifts left)
  logic [WIDTH-1:0] acc_hi;    // product high half or partial remainder
  logic [WIDTH-1:0] acc_lo;    // product low half or quotient

  logic             sign_a, sign_b;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] fix_hi, fix_lo;
  logic [2*WIDTH-1:0] prod;

  function automatic logic [WIDTH-1:0] cond_neg_w(input logic [WIDTH-1:0] x, input logic en);
    return en ? (~x + 1'b1) : x;
  endfunction

  function automatic logic [2*WIDTH-1:0] cond_neg_d(input logic [2*WIDTH-1:0] x, input logic en);
    return en ? (~x + 1'b1) : x;
  endfunction

  assign accept = start && (state == IDLE || state == DONE);
  assign hi_we  = done;
  assign lo_we  = done;

  // Magnitudes of the incoming operands; 0x80000000 stays 0x80000000 as unsigned.
  assign sign_a = ~op[0] & a[WIDTH-1];
  assign sign_b = ~op[0] & b[WIDTH-1];
  assign mag_a  = cond_neg_w(a, sign_a);
  assign mag_b  = cond_neg_w(b, sign_b);

  // Shift-add step and restoring-division trial subtraction.
  assign sum   = {1'b0, acc_hi} + (opr[0] ? {1'b0, addend} : '0);
  assign trial = {acc_hi, opr[WIDTH-1]} - {1'b0, addend};

  always_comb begin
    prod   = cond_neg_d({acc_hi, acc_lo}, neg_q);
    fix_hi = prod[2*WIDTH-1:WIDTH];
    fix_lo = prod[WIDTH-1:0];
    if (is_div) begin
      if (b_zero) begin
        fix_hi = a_raw;
        fix_lo = '1;
      end else begin
        fix_hi = cond_neg_w(acc_hi, neg_r);
        fix_lo = cond_neg_w(acc_lo, neg_q);
      end
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE, DONE: state_nx = start ? CALC : IDLE;
      CALC:       if (cnt == CW'(WIDTH-1)) state_nx = FIX;
      FIX:        state_nx = DONE;
      default:    state_nx = IDLE;
    endcase
  end

  // Control and architecturally visible outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      hi_out <= '0;
      lo_out <= '0;
    end else begin
      state <= state_nx;
      busy  <= (state_nx == CALC) || (state_nx == FIX);
      done  <= (state_nx == DONE);
      if (accept)
        cnt <= '0;
      else if (state == CALC)
        cnt <= cnt + CW'(1);
      if (state == FIX) begin
        hi_out <= fix_hi;
        lo_out <= fix_lo;
      end
    end
  end

  // Datapath: operand capture on accept, one iteration per CALC cycle.
  always_ff @(posedge clk) begin
    if (accept) begin
      is_div <= op[1];
      neg_q  <= sign_a ^ sign_b;
      neg_r  <= sign_a;
      b_zero <= (b == '0);
      a_raw  <= a;
      addend <= op[1] ? mag_b : mag_a;
      opr    <= op[1] ? mag_a : mag_b;
      acc_hi <= '0;
      acc_lo <= '0;
    end else if (state == CALC) begin
      if (is_div) begin
        // Non-negative trial keeps the subtraction and yields a 1 quotient bit.
        acc_hi <= trial[WIDTH] ? {acc_hi[WIDTH-2:0], opr[WIDTH-1]} : trial[WIDTH-1:0];
        acc_lo <= {acc_lo[WIDTH-2:0], ~trial[WIDTH]};
        opr    <= {opr[WIDTH-2:0], 1'b0};
      end else begin
        acc_hi <= sum[WIDTH:1];
        acc_lo <= {sum[0], acc_lo[WIDTH-1:1]};
        opr    <= {1'b0, opr[WIDTH-1:1]};
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Testbench for muldiv_unit: random and directed MULT/MULTU/DIV/DIVU
// operations compared against a plain-arithmetic reference model.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a, b;
  logic        busy, done, hi_we, lo_we;
  logic [31:0] hi_out, lo_out;

  int          n_chk = 0;
  int          n_err = 0;
  logic [63:0] prev;

  always #5 clk = ~clk;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .hi_out (hi_out),
    .lo_out (lo_out),
    .hi_we  (hi_we),
    .lo_we  (lo_we)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Returns {hi, lo} as MIPS defines them.
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, q, r;
    logic [63:0] ux, uy;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'b0, x};
    uy = {32'b0, y};
    case (o)
      2'b00: return 64'(sx * sy);
      2'b01: return ux * uy;
      default: begin
        if (y == 32'b0) return {x, 32'hFFFF_FFFF};
        if (o == 2'b11) return {32'(ux % uy), 32'(ux / uy)};
        q = sx / sy;
        r = sx % sy;
        return {r[31:0], q[31:0]};
      end
    endcase
  endfunction

  // Called at a falling edge; returns at the falling edge inside the done cycle.
  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        input string tag, input int inj, output logic [63:0] res);
    int k, bcnt;
    logic [63:0] exp;
    exp   = model(o, x, y);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; op = 2'($urandom); a = $urandom; b = $urandom;
    k = 1; bcnt = 0;
    while (!done && k < 60) begin
      if (busy) bcnt++;
      if (k == 5) chk({tag, "_hold"}, {hi_out, lo_out}, prev);
      start = (k == inj);
      if (k == inj) op = ~o;
      @(negedge clk);
      k++;
    end
    start = 1'b0;
    chk({tag, "_latency"}, 64'(k), 64'd34);
    chk({tag, "_busycyc"}, 64'(bcnt), 64'd33);
    chk({tag, "_busy_at_done"}, 64'(busy), 64'd0);
    chk({tag, "_we"}, {62'b0, hi_we, lo_we}, 64'd3);
    chk({tag, "_result"}, {hi_out, lo_out}, exp);
    res  = {hi_out, lo_out};
    prev = exp;
  endtask

  initial begin
    logic [63:0] r;
    logic [1:0]  o;
    logic [31:0] x, y;
    int          gap, dcnt;

    rst = 1'b1; start = 1'b0; op = 2'b0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_we", {62'b0, hi_we, lo_we}, 64'd0);
    chk("rst_hilo", {hi_out, lo_out}, 64'd0);
    rst = 1'b0;
    @(negedge clk);
    prev = '0;

    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max", 0, r);
    chk("multu_max_const", r, 64'hFFFF_FFFE_0000_0001);
    @(negedge clk);
    chk("done_one_cycle", {62'b0, done, hi_we}, 64'd0);
    chk("result_held", {hi_out, lo_out}, prev);

    run_op(2'b00, 32'hFFFF_FFFD, 32'd5, "mult_neg", 0, r);
    chk("mult_neg_const", r, 64'hFFFF_FFFF_FFFF_FFF1);
    run_op(2'b11, 32'd100, 32'd7, "divu", 0, r);
    chk("divu_const", r, {32'd2, 32'd14});
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, "div_neg", 0, r);
    chk("div_neg_const", r, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf", 0, r);
    chk("div_ovf_const", r, 64'h0000_0000_8000_0000);
    run_op(2'b11, 32'd5, 32'd0, "divu_zero", 0, r);
    chk("divu_zero_const", r, 64'h0000_0005_FFFF_FFFF);
    run_op(2'b10, 32'hFFFF_FFFB, 32'd0, "div_zero", 0, r);
    chk("div_zero_const", r, 64'hFFFF_FFFB_FFFF_FFFF);
    run_op(2'b01, 32'h1234_5678, 32'h9ABC_DEF0, "ignore_start", 10, r);

    // Reset in the middle of an operation.
    @(negedge clk);
    start = 1'b1; op = 2'b01; a = 32'hDEAD_BEEF; b = 32'h0000_1234;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_done", {62'b0, done, hi_we}, 64'd0);
    chk("midrst_hilo", {hi_out, lo_out}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    dcnt = 0;
    repeat (50) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    chk("midrst_no_done", 64'(dcnt), 64'd0);
    prev = '0;

    for (int i = 0; i < 30; i++) begin
      o = 2'($urandom);
      x = $urandom;
      y = $urandom;
      case ($urandom_range(0, 7))
        0: y = 32'd0;
        1: begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
        2: y = 32'($urandom_range(1, 15));
        3: x = 32'($urandom_range(0, 100));
        default: ;
      endcase
      gap = $urandom_range(0, 2);
      repeat (gap) begin
        @(negedge clk);
        chk("gap_held", {hi_out, lo_out}, prev);
        chk("gap_no_done", 64'(done), 64'd0);
      end
      run_op(o, x, y, $sformatf("rand%0d_op%0d", i, o), 0, r);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
